spi_cmd_master: RTL and testbench
=================================

Name: spi_cmd_master

Overview:
- Master-side command driver for the SPI execution-unit slave.
- Takes one parallel command (operation code, argument A, argument B) over a valid/ready handshake and serialises it onto MOSI within a chip-select frame.
- After a fixed turnaround it deserialises the slave's result and flags from MISO and presents them with a one-cycle valid pulse.
- Sits directly upstream of the execution-unit slave and drives its i_cs and i_mosi from the shared i_sclk.

Parameters:
- OPER_W, 4, operation-code width.
- ARG_W, 8, width of each argument and of the result.
- FLAG_W, 4, flag field width.
- TURN_CYC, 3, cycles between the last MOSI bit and the first MISO sample (>=1).
- CS_GAP, 2, minimum cycles o_cs stays high between frames (>=1).

Ports:
- i_sclk  input  1  SPI clock; all state updates on its rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_valid  input  1  command valid.
- o_ready  output  1  block can accept a command.
- i_oper  input  OPER_W  operation code.
- i_argA  input  ARG_W  argument A.
- i_argB  input  ARG_W  argument B.
- o_cs  output  1  chip select to slave, active-low.
- o_mosi  output  1  serial data to slave.
- i_miso  input  1  serial data from slave.
- o_valid  output  1  response valid, one-cycle pulse.
- o_result  output  ARG_W  captured result.
- o_flags  output  FLAG_W  captured flags; bit3 BF, bit2 NF, bit1 OF, bit0 SF.
- o_busy  output  1  high whenever o_cs is low or the gap is running.

Behaviour:
- Reset values: o_cs=1, o_mosi=0, o_valid=0, o_result=0, o_flags=0, o_busy=0, o_ready=1; FSM in IDLE; all counters cleared.
- All outputs are registered on the i_sclk rising edge.
- Accept condition: i_valid && o_ready at a rising edge (edge 0). The command is latched into a TX shift register {oper, argA, argB} of SEND_W = OPER_W + 2*ARG_W bits (20 by default). i_valid while o_ready=0 is ignored; nothing is latched.
- FSM states:
  - IDLE: o_cs=1, o_ready=1. On accept go to SEND.
  - SEND: o_cs=0, o_mosi = current MSB of the TX register, shift left one bit per cycle, MSB first (oper[3] first, argB[0] last). After edge k (k = 0..SEND_W-1), o_mosi holds bit SEND_W-1-k. After SEND_W cycles go to TURN.
  - TURN: o_cs=0, o_mosi=0 for TURN_CYC cycles, then go to RECV.
  - RECV: o_cs=0, o_mosi=0. Shift i_miso into the RX register at each rising edge ending a RECV cycle, MSB first, for RESP_W = ARG_W + FLAG_W cycles (12 by default). At the final sample edge: o_result = RX[RESP_W-1:FLAG_W], o_flags = RX[FLAG_W-1:0], o_valid=1 for exactly one cycle, o_cs=1. Then go to GAP.
  - GAP: o_cs=1, o_ready=0 for CS_GAP cycles, then go to IDLE.
- Default timing (accept at edge 0): o_cs falls after edge 0; last MOSI bit is held until edge 20; TURN spans edges 20-23; samples at edges 24..35; o_valid and o_cs=1 after edge 35; o_ready=1 after edge 37.
- o_result and o_flags hold their value until the next response; they are not cleared by o_valid deasserting.
- o_busy = !(state==IDLE).
- Reset mid-frame: o_cs rises immediately (asynchronously), the partial command and response are discarded, and the FSM returns to IDLE.
- No abort path other than reset; i_valid changes during a frame have no effect.

Optional Feature:
SPI_CMD_MASTER_QUEUE_EN:
- Defined: adds a one-entry command holding register.
  - o_ready = !hold_full in every state, including during a frame.
  - A command accepted while busy is stored and launched at the end of GAP: SEND is entered directly and o_cs falls exactly CS_GAP cycles after the previous rise.
  - A command accepted in IDLE with the holder empty launches as in the base behaviour.
  - Reset clears the holder.
- Undefined: no holder; o_ready is high only in IDLE.

Test Plan:
- Reset: hold i_rst=0 -> o_cs=1, o_mosi=0, o_valid=0, o_ready=1, o_result=0, o_flags=0.
- Single frame: oper=4'hA, A=8'h3C, B=8'h81 accepted at edge 0 -> o_mosi sequence 1010_00111100_10000001 after edges 0..19, o_cs low from edge 0 through edge 35. Slave model drives MISO 8'h5A then 4'b0011 at sample edges 24..35 -> after edge 35: o_valid=1 for one cycle, o_result=8'h5A, o_flags=4'h3.
- Back-pressure: i_valid held high through the frame with changing data -> only the first command is sent; the second is accepted no earlier than edge 37 when o_ready returns.
- Boundary data: oper=4'hF, A=8'hFF, B=8'h00 with all-ones MISO -> MOSI shows 12 ones then 8 zeros; o_result=8'hFF, o_flags=4'hF.
- Reset mid-frame: assert i_rst low at edge 10 -> o_cs=1 immediately, no o_valid; next command after release produces a full correct frame.
- With SPI_CMD_MASTER_QUEUE_EN: second command presented at edge 5 -> accepted, o_cs high only during edges 35-37, second frame o_cs falls after edge 37, MOSI carries the second command.

Source files
------------

// File: rtl/spi_cmd_master.sv
// SPI command master: serialises {oper, argA, argB} onto MOSI, then captures {result, flags} from MISO.
// Optional macro SPI_CMD_MASTER_QUEUE_EN adds a one-entry command holder so a frame can be queued while busy.
module spi_cmd_master #(
  parameter int OPER_W   = 4,
  parameter int ARG_W    = 8,
  parameter int FLAG_W   = 4,
  parameter int TURN_CYC = 3,
  parameter int CS_GAP   = 2
) (
  input  logic              i_sclk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OPER_W-1:0] i_oper,
  input  logic [ARG_W-1:0]  i_argA,
  input  logic [ARG_W-1:0]  i_argB,
  output logic              o_cs,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_valid,
  output logic [ARG_W-1:0]  o_result,
  output logic [FLAG_W-1:0] o_flags,
  output logic              o_busy
);

  localparam int SEND_W = OPER_W + 2 * ARG_W;
  localparam int RESP_W = ARG_W + FLAG_W;
  localparam int CNT_W  = $clog2(SEND_W + RESP_W + TURN_CYC + CS_GAP);

  typedef enum logic [2:0] {IDLE, SEND, TURN, RECV, GAP} state_t;

  state_t             state_q, state_d;
  logic [SEND_W-1:0]  txShift_q, txShift_d;
  logic [RESP_W-1:0]  rxShift_q, rxShift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [ARG_W-1:0]   result_q, result_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic               accept;
  logic               launch;
  logic [SEND_W-1:0]  newCmd;
  logic [SEND_W-1:0]  launchCmd;
`ifdef SPI_CMD_MASTER_QUEUE_EN
  logic [SEND_W-1:0]  hold_q, hold_d;
  logic               holdFull_q, holdFull_d;
`endif

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      txShift_q <= '0;
      rxShift_q <= '0;
      cnt_q     <= '0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
`ifdef SPI_CMD_MASTER_QUEUE_EN
      hold_q     <= '0;
      holdFull_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
`ifdef SPI_CMD_MASTER_QUEUE_EN
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    cnt_d     = cnt_q;
    mosi_d    = 1'b0;
    valid_d   = 1'b0;
    result_d  = result_q;
    flags_d   = flags_q;
    newCmd    = {i_oper, i_argA, i_argB};
    accept    = i_valid && ready_q;
    launch    = 1'b0;
`ifdef SPI_CMD_MASTER_QUEUE_EN
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    launchCmd  = holdFull_q ? hold_q : newCmd;
`else
    launchCmd  = newCmd;
`endif

    case (state_q)
      IDLE: begin
`ifdef SPI_CMD_MASTER_QUEUE_EN
        launch = accept || holdFull_q;
`else
        launch = accept;
`endif
      end
      SEND: begin
        if (cnt_q == CNT_W'(SEND_W - 1)) begin
          state_d = TURN;
          cnt_d   = '0;
        end else begin
          mosi_d    = txShift_q[SEND_W-1];
          txShift_d = txShift_q << 1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      TURN: begin
        if (cnt_q == CNT_W'(TURN_CYC - 1)) begin
          state_d = RECV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECV: begin
        rxShift_d = {rxShift_q[RESP_W-2:0], i_miso};
        if (cnt_q == CNT_W'(RESP_W - 1)) begin
          result_d = rxShift_d[RESP_W-1:FLAG_W];
          flags_d  = rxShift_d[FLAG_W-1:0];
          valid_d  = 1'b1;
          state_d  = GAP;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef SPI_CMD_MASTER_QUEUE_EN
          launch  = holdFull_q || accept;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef SPI_CMD_MASTER_QUEUE_EN
    // A command arriving mid-frame parks in the holder until the gap expires.
    if (launch && holdFull_q) begin
      holdFull_d = 1'b0;
    end else if (accept && !launch) begin
      hold_d     = newCmd;
      holdFull_d = 1'b1;
    end
`endif

    if (launch) begin
      state_d   = SEND;
      cnt_d     = '0;
      mosi_d    = launchCmd[SEND_W-1];
      txShift_d = launchCmd << 1;
    end

    cs_d   = !(state_d inside {SEND, TURN, RECV});
    busy_d = (state_d != IDLE);
`ifdef SPI_CMD_MASTER_QUEUE_EN
    ready_d = !holdFull_d;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  assign o_cs     = cs_q;
  assign o_mosi   = mosi_q;
  assign o_valid  = valid_q;
  assign o_ready  = ready_q;
  assign o_busy   = busy_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: directed and random frames against a bit-level frame model.
// Queued-frame scenario is exercised only when SPI_CMD_MASTER_QUEUE_EN is defined.
module tb_spi_cmd_master;

  localparam int SEND_W = 20;
  localparam int RESP_W = 12;

  logic        i_sclk = 1'b0;
  logic        i_rst  = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_oper = '0;
  logic [7:0]  i_argA = '0;
  logic [7:0]  i_argB = '0;
  logic        o_cs;
  logic        o_mosi;
  logic        i_miso = 1'b0;
  logic        o_valid;
  logic [7:0]  o_result;
  logic [3:0]  o_flags;
  logic        o_busy;

  int checkCount = 0;
  int passCount  = 0;

  spi_cmd_master dut (
    .i_sclk  (i_sclk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_oper  (i_oper),
    .i_argA  (i_argA),
    .i_argB  (i_argB),
    .o_cs    (o_cs),
    .o_mosi  (o_mosi),
    .i_miso  (i_miso),
    .o_valid (o_valid),
    .o_result(o_result),
    .o_flags (o_flags),
    .o_busy  (o_busy)
  );

  always #5 i_sclk = ~i_sclk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [SEND_W-1:0] cmd);
    i_oper  = cmd[19:16];
    i_argA  = cmd[15:8];
    i_argB  = cmd[7:0];
    i_valid = 1'b1;
  endtask

  // One frame as seen from the pins: cmd leaves MSB first, resp = {result, flags} is returned MSB first.
  task automatic runFrame(input logic [SEND_W-1:0] cmd, input logic [RESP_W-1:0] resp,
                          input int injectAt, input logic [SEND_W-1:0] injCmd, input bit injHold,
                          input bit chained, input bit chainNext);
    logic [31:0] expReady;
    int waitCyc;
    if (!chained) begin
      waitCyc = 0;
      while (o_ready !== 1'b1 && waitCyc < 100) begin
        tick();
        waitCyc++;
      end
      checkOutput("readyBeforeAccept", {31'b0, o_ready}, 32'd1);
      applyStimulus(cmd);
    end
    tick();
    if (!chained && !injHold) i_valid = 1'b0;
    for (int k = 0; k < SEND_W; k++) begin
      if (k > 0) tick();
      if (k == injectAt) applyStimulus(injCmd);
      if (injHold && k > injectAt && k < SEND_W - 1) applyStimulus(SEND_W'($urandom));
      if (injHold && k == SEND_W - 1) applyStimulus(injCmd);
      if (!injHold && k == injectAt + 1) i_valid = 1'b0;
      checkOutput("mosiBit", {31'b0, o_mosi}, {31'b0, cmd[SEND_W-1-k]});
      checkOutput("csSend", {31'b0, o_cs}, 32'd0);
    end
`ifdef SPI_CMD_MASTER_QUEUE_EN
    expReady = (injectAt >= 0 && injectAt < SEND_W - 1) ? 32'd0 : 32'd1;
`else
    expReady = 32'd0;
`endif
    checkOutput("readyInFrame", {31'b0, o_ready}, expReady);
    checkOutput("busyInFrame", {31'b0, o_busy}, 32'd1);
    for (int e = 0; e < 4; e++) begin
      tick();
      checkOutput("mosiTurn", {31'b0, o_mosi}, 32'd0);
      checkOutput("csTurn", {31'b0, o_cs}, 32'd0);
    end
    i_miso = resp[RESP_W-1];
    for (int j = 0; j < RESP_W; j++) begin
      tick();
      if (j < RESP_W - 1) begin
        checkOutput("validEarly", {31'b0, o_valid}, 32'd0);
        checkOutput("csRecv", {31'b0, o_cs}, 32'd0);
        i_miso = resp[RESP_W-2-j];
      end
    end
    i_miso = 1'($urandom);
    checkOutput("validPulse", {31'b0, o_valid}, 32'd1);
    checkOutput("result", {24'b0, o_result}, {24'b0, resp[11:4]});
    checkOutput("flags", {28'b0, o_flags}, {28'b0, resp[3:0]});
    checkOutput("csEnd", {31'b0, o_cs}, 32'd1);
    tick();
    checkOutput("validOneCycle", {31'b0, o_valid}, 32'd0);
    checkOutput("csGap", {31'b0, o_cs}, 32'd1);
    checkOutput("resultHeld", {24'b0, o_result}, {24'b0, resp[11:4]});
    checkOutput("busyGap", {31'b0, o_busy}, 32'd1);
`ifdef SPI_CMD_MASTER_QUEUE_EN
    expReady = (injectAt >= 0) ? 32'd0 : 32'd1;
`else
    expReady = 32'd0;
`endif
    checkOutput("readyGap", {31'b0, o_ready}, expReady);
    if (!chainNext) begin
      tick();
      checkOutput("readyAfterGap", {31'b0, o_ready}, 32'd1);
      checkOutput("csIdle", {31'b0, o_cs}, 32'd1);
      checkOutput("busyIdle", {31'b0, o_busy}, 32'd0);
    end
  endtask

  initial begin
    logic [SEND_W-1:0] cmd;
    logic [SEND_W-1:0] cmd2;
    logic [RESP_W-1:0] resp;

    $display("[TB] reset checks");
    #2 i_rst = 1'b0;
    #1;
    checkOutput("rstCs", {31'b0, o_cs}, 32'd1);
    checkOutput("rstMosi", {31'b0, o_mosi}, 32'd0);
    checkOutput("rstValid", {31'b0, o_valid}, 32'd0);
    checkOutput("rstReady", {31'b0, o_ready}, 32'd1);
    checkOutput("rstResult", {24'b0, o_result}, 32'd0);
    checkOutput("rstFlags", {28'b0, o_flags}, 32'd0);
    checkOutput("rstBusy", {31'b0, o_busy}, 32'd0);
    tick();
    tick();
    #3 i_rst = 1'b1;
    tick();

    $display("[TB] directed frame");
    runFrame({4'hA, 8'h3C, 8'h81}, {8'h5A, 4'h3}, -1, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] boundary frame");
    runFrame({4'hF, 8'hFF, 8'h00}, {8'hFF, 4'hF}, -1, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] random frames");
    for (int n = 0; n < 4; n++) begin
      cmd  = SEND_W'($urandom);
      resp = RESP_W'($urandom);
      runFrame(cmd, resp, -1, '0, 1'b0, 1'b0, 1'b0);
    end

`ifndef SPI_CMD_MASTER_QUEUE_EN
    $display("[TB] back-pressure");
    cmd  = SEND_W'($urandom);
    cmd2 = ~cmd;
    resp = RESP_W'($urandom);
    runFrame(cmd, resp, 2, cmd2, 1'b1, 1'b0, 1'b0);
    resp = RESP_W'($urandom);
    runFrame(cmd2, resp, -1, '0, 1'b0, 1'b0, 1'b0);
`else
    $display("[TB] queued command");
    cmd  = SEND_W'($urandom);
    cmd2 = SEND_W'($urandom);
    resp = RESP_W'($urandom);
    runFrame(cmd, resp, 4, cmd2, 1'b0, 1'b0, 1'b1);
    resp = RESP_W'($urandom);
    runFrame(cmd2, resp, -1, '0, 1'b0, 1'b1, 1'b0);
`endif

    $display("[TB] reset mid-frame");
    cmd = SEND_W'($urandom);
    applyStimulus(cmd);
    tick();
    i_valid = 1'b0;
    repeat (9) tick();
    #2 i_rst = 1'b0;
    #1;
    checkOutput("midRstCs", {31'b0, o_cs}, 32'd1);
    checkOutput("midRstBusy", {31'b0, o_busy}, 32'd0);
    checkOutput("midRstReady", {31'b0, o_ready}, 32'd1);
    checkOutput("midRstResult", {24'b0, o_result}, 32'd0);
    tick();
    tick();
    checkOutput("midRstNoValid", {31'b0, o_valid}, 32'd0);
    checkOutput("midRstCsHeld", {31'b0, o_cs}, 32'd1);
    #2 i_rst = 1'b1;
    tick();
    cmd  = SEND_W'($urandom);
    resp = RESP_W'($urandom);
    runFrame(cmd, resp, -1, '0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
